nibble_unswap_rx: RTL and testbench

Receive-side partner of the nibble-swap output stage. It accepts a nibble-serial stream of swapped bytes, reassembles each pair of nibbles into the original byte (undoing the swap), and buffers the results in a small FIFO. The FIFO drains over a valid/ready byte interface. The block sits between the dedicated-input pins and the byte-consuming logic in the tile, and reports framing errors.

---
 rtl/nibble_unswap_rx_if.sv | 21 ++
 rtl/nibble_unswap_rx.sv | 119 +++++++++++
 tb/tb_nibble_unswap_rx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_unswap_rx_if.sv
// Stream bundle for nibble_unswap_rx: nibble-serial input side and the
// valid/ready byte output side.
interface nibble_unswap_rx_if;
    logic       nib_valid;
    logic [3:0] nib_data;
    logic       nib_sof;
    logic       nib_ready;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport slave (
        input  nib_valid, nib_data, nib_sof, byte_ready,
        output nib_ready, byte_valid, byte_data
    );

    modport master (
        output nib_valid, nib_data, nib_sof, byte_ready,
        input  nib_ready, byte_valid, byte_data
    );
endinterface

// File: rtl/nibble_unswap_rx.sv
// Reassembles nibble-swapped bytes from a nibble stream into a byte FIFO.
// Define NIBBLE_RX_STATS_EN to build the saturating framing-error counter.
module nibble_unswap_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    nibble_unswap_rx_if.slave            bus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         sync_err,
    output logic [7:0]                   err_cnt
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    localparam logic [0:0] EXPECT_FIRST  = 1'b0;
    localparam logic [0:0] EXPECT_SECOND = 1'b1;

    logic [0:0]    phase_q, phase_d;
    logic [3:0]    hold_q, hold_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic          sync_err_q, sync_err_d;

    logic full, xfer, push, pop, frame_err;

    always_comb begin
        full      = (count_q == DEPTH_L);
        xfer      = bus.nib_valid && !full;
        pop       = (count_q != '0) && bus.byte_ready;
        push      = 1'b0;
        frame_err = 1'b0;
        phase_d   = phase_q;
        hold_d    = hold_q;

        // A sof nibble always restarts a byte; a stray second nibble is dropped.
        if (xfer) begin
            if (phase_q == EXPECT_FIRST) begin
                if (bus.nib_sof) begin
                    hold_d  = bus.nib_data;
                    phase_d = EXPECT_SECOND;
                end else begin
                    frame_err = 1'b1;
                end
            end else begin
                if (bus.nib_sof) begin
                    hold_d    = bus.nib_data;
                    frame_err = 1'b1;
                end else begin
                    push    = 1'b1;
                    phase_d = EXPECT_FIRST;
                end
            end
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.nib_data, hold_q};
        end
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        sync_err_d = frame_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= EXPECT_FIRST;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sync_err_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sync_err_q <= sync_err_d;
            mem_q      <= mem_d;
        end
    end

`ifdef NIBBLE_RX_STATS_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    assign bus.nib_ready  = !full;
    assign bus.byte_valid = (count_q != '0);
    assign bus.byte_data  = mem_q[rd_ptr_q];
    assign fifo_level     = count_q;
    assign sync_err       = sync_err_q;
endmodule

// File: tb/tb_nibble_unswap_rx.sv
// Self-checking bench for nibble_unswap_rx: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_nibble_unswap_rx;
    localparam int DEPTH = 4;
`ifdef NIBBLE_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fifoLevel;
    logic       syncErr;
    logic [7:0] errCnt;

    int checks = 0;
    int errors = 0;

    nibble_unswap_rx_if busIf ();

    nibble_unswap_rx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (busIf),
        .fifo_level (fifoLevel),
        .sync_err   (syncErr),
        .err_cnt    (errCnt)
    );

    always #5 clk = ~clk;

    // Reference model: byte queue plus "waiting for second nibble" flag.
    logic [7:0] mq [$];
    bit         mSecond;
    logic [3:0] mHold;
    bit         mErr;
    int         mErrCnt;

    typedef struct {
        logic       nv;
        logic [3:0] nd;
        logic       sof;
        logic       br;
        logic       expValid;
        logic [7:0] expData;
        logic [2:0] expLevel;
        logic       expErr;
        int         errEvents;
    } vecT;

    vecT vecs [8];

    task automatic resetModel();
        mq.delete();
        mSecond = 1'b0;
        mHold   = 4'h0;
        mErr    = 1'b0;
        mErrCnt = 0;
    endtask

    task automatic modelStep(input logic nv, input logic [3:0] nd, input logic sof, input logic br);
        bit         accept;
        bit         doPush;
        bit         doPop;
        logic [7:0] newByte;
        accept  = nv && (mq.size() < DEPTH);
        doPop   = br && (mq.size() > 0);
        doPush  = 1'b0;
        newByte = 8'h00;
        mErr    = 1'b0;
        if (accept) begin
            if (sof) begin
                mErr    = mSecond;
                mHold   = nd;
                mSecond = 1'b1;
            end else if (mSecond) begin
                newByte = {nd, mHold};
                doPush  = 1'b1;
                mSecond = 1'b0;
            end else begin
                mErr = 1'b1;
            end
        end
        if (mErr && mErrCnt < 255) mErrCnt++;
        if (doPop) void'(mq.pop_front());
        if (doPush) mq.push_back(newByte);
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expReady, input logic expValid,
                               input logic [7:0] expData, input logic [2:0] expLevel,
                               input logic expErr, input logic [7:0] expCnt);
        checkVal({tag, ".nib_ready"}, 32'(busIf.nib_ready), 32'(expReady));
        checkVal({tag, ".byte_valid"}, 32'(busIf.byte_valid), 32'(expValid));
        if (expValid) checkVal({tag, ".byte_data"}, 32'(busIf.byte_data), 32'(expData));
        checkVal({tag, ".fifo_level"}, 32'(fifoLevel), 32'(expLevel));
        checkVal({tag, ".sync_err"}, 32'(syncErr), 32'(expErr));
        checkVal({tag, ".err_cnt"}, 32'(errCnt), 32'(expCnt));
    endtask

    task automatic checkModel(input string tag);
        logic [7:0] head;
        head = (mq.size() > 0) ? mq[0] : 8'h00;
        checkOutput(tag, mq.size() < DEPTH, mq.size() > 0, head, 3'(mq.size()),
                    mErr, STATS ? 8'(mErrCnt) : 8'h00);
    endtask

    task automatic drive(input logic nv, input logic [3:0] nd, input logic sof, input logic br);
        busIf.nib_valid  = nv;
        busIf.nib_data   = nd;
        busIf.nib_sof    = sof;
        busIf.byte_ready = br;
    endtask

    task automatic applyStimulus(input string tag, input logic nv, input logic [3:0] nd,
                                 input logic sof, input logic br);
        drive(nv, nd, sof, br);
        modelStep(nv, nd, sof, br);
        @(posedge clk);
        #1;
        checkModel(tag);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        resetModel();
        #12;
        checkOutput("reset", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
        checkVal("reset.byte_data", 32'(busIf.byte_data), 32'h0);
        rst = 1'b0;

        // Directed vectors: basic byte, resync, stray second nibble.
        vecs[0] = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 0};
        vecs[1] = '{1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 8'hCA, 3'd1, 1'b0, 0};
        vecs[2] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 0};
        vecs[3] = '{1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 0};
        vecs[4] = '{1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1};
        vecs[5] = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 8'h72, 3'd1, 1'b0, 1};
        vecs[6] = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 2};
        vecs[7] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 2};
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].nv, vecs[i].nd, vecs[i].sof, vecs[i].br);
            modelStep(vecs[i].nv, vecs[i].nd, vecs[i].sof, vecs[i].br);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), 1'b1, vecs[i].expValid, vecs[i].expData,
                        vecs[i].expLevel, vecs[i].expErr, STATS ? 8'(vecs[i].errEvents) : 8'h00);
        end

        // Fill to full, refuse a first nibble, then drain and complete byte five.
        for (int k = 0; k < 4; k++) begin
            applyStimulus("fill", 1'b1, 4'(k + 1), 1'b1, 1'b0);
            applyStimulus("fill", 1'b1, 4'(k + 8), 1'b0, 1'b0);
        end
        checkVal("full.level", 32'(fifoLevel), 32'd4);
        checkVal("full.nib_ready", 32'(busIf.nib_ready), 32'd0);
        checkVal("full.head", 32'(busIf.byte_data), 32'h81);
        applyStimulus("full_hold", 1'b1, 4'h5, 1'b1, 1'b0);
        applyStimulus("full_hold", 1'b1, 4'h5, 1'b1, 1'b0);
        applyStimulus("full_pop", 1'b1, 4'h5, 1'b1, 1'b1);
        checkVal("full_pop.nib_ready", 32'(busIf.nib_ready), 32'd1);
        checkVal("full_pop.head", 32'(busIf.byte_data), 32'h92);
        applyStimulus("fifth", 1'b1, 4'h5, 1'b1, 1'b1);
        applyStimulus("fifth", 1'b1, 4'hD, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus("drain", 1'b0, 4'h0, 1'b0, 1'b1);

        // Simultaneous push and pop at level 2 across pointer wrap.
        applyStimulus("lvl2", 1'b1, 4'h1, 1'b1, 1'b0);
        applyStimulus("lvl2", 1'b1, 4'hE, 1'b0, 1'b0);
        applyStimulus("lvl2", 1'b1, 4'h2, 1'b1, 1'b0);
        applyStimulus("lvl2", 1'b1, 4'hD, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus("wrap", 1'b1, 4'(k), 1'b1, 1'b0);
            applyStimulus("wrap", 1'b1, 4'(15 - k), 1'b0, 1'b1);
            checkVal("wrap.level", 32'(fifoLevel), 32'd2);
        end
        for (int k = 0; k < 3; k++) applyStimulus("drain2", 1'b0, 4'h0, 1'b0, 1'b1);

        // Asynchronous reset mid-byte with three bytes queued.
        for (int k = 0; k < 3; k++) begin
            applyStimulus("pre_rst", 1'b1, 4'(k + 3), 1'b1, 1'b0);
            applyStimulus("pre_rst", 1'b1, 4'(k + 6), 1'b0, 1'b0);
        end
        applyStimulus("pre_rst", 1'b1, 4'h9, 1'b1, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        resetModel();
        checkOutput("async_rst", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("post_rst", 1'b1, 4'h5, 1'b0, 1'b1);
        checkVal("post_rst.sync_err", 32'(syncErr), 32'd1);

        // Randomized traffic: low then high consumer readiness.
        for (int k = 0; k < 400; k++) begin
            logic nv, sof, br;
            nv  = ($urandom_range(0, 3) != 0);
            sof = mSecond ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
            br  = (k < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            applyStimulus("rand", nv, 4'($urandom_range(0, 15)), sof, br);
        end

        // Error counter saturation via a long run of stray second nibbles.
        for (int k = 0; k < 4; k++) applyStimulus("flush", 1'b0, 4'h0, 1'b0, 1'b1);
        applyStimulus("flush", 1'b1, 4'h0, 1'b0, 1'b1);
        for (int k = 0; k < 260; k++) applyStimulus("sat", 1'b1, 4'(k), 1'b0, 1'b1);
        checkVal("sat.err_cnt", 32'(errCnt), STATS ? 32'd255 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
